branch_predict_unit: RTL and testbench

- Next-generation fetch-stage branch hardware: gshare direction predictor plus 2-way set-associative BTB with LRU replacement.
- Fully parametrised in counter width, PHT depth, history length and BTB sets.
- Tables are initialised by a hardware sweep after reset.
- Lookup is combinational in the fetch cycle. Updates arrive from the resolve stage, carrying the history snapshot taken at fetch.

---
 rtl/branch_predict_unit.sv | 175 +++++++++++++++++
 tb/tb_branch_predict_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: gshare direction predictor plus a 2-way set-associative
// BTB with one LRU bit per set. The tables are cleared by a hardware sweep after
// reset. Lookup is combinational. Updates from the resolve stage are written on
// the clock edge.
// Optional build macro BP_STATS_EN adds the resolved_pred input and the
// stat_updates / stat_mispredicts counters.
module branch_predict_unit #(
  parameter int DATA_WIDTH    = 32,
  parameter int COUNTER_WIDTH = 2,
  parameter int PHT_ENTRIES   = 256,
  parameter int GHR_WIDTH     = 8,
  parameter int BTB_SETS      = 64
) (
  input  logic                  clk,
  input  logic                  rstn,
  output logic                  ready,
  input  logic [DATA_WIDTH-1:0] pc,
  output logic                  hit,
  output logic                  pred,
  output logic [DATA_WIDTH-1:0] branch_target,
  output logic [GHR_WIDTH-1:0]  ghr,
  input  logic                  update_predictor,
  input  logic                  update_btb,
  input  logic                  actually_taken,
  input  logic [DATA_WIDTH-1:0] resolved_pc,
  input  logic [DATA_WIDTH-1:0] resolved_pc_target,
  input  logic [GHR_WIDTH-1:0]  resolved_ghr
`ifdef BP_STATS_EN
  ,
  input  logic                  resolved_pred,
  output logic [31:0]           stat_updates,
  output logic [31:0]           stat_mispredicts
`endif
);

  localparam int PHT_IDX  = $clog2(PHT_ENTRIES);
  localparam int BTB_IDX  = $clog2(BTB_SETS);
  localparam int TAG_W    = DATA_WIDTH - BTB_IDX - 2;
  localparam int INIT_N   = (PHT_ENTRIES > BTB_SETS) ? PHT_ENTRIES : BTB_SETS;
  localparam int IW       = $clog2(INIT_N);
  localparam logic [COUNTER_WIDTH-1:0] CNT_MAX  = {COUNTER_WIDTH{1'b1}};
  localparam logic [COUNTER_WIDTH-1:0] CNT_INIT = CNT_MAX >> 1;

  typedef enum logic {S_INIT, S_READY} state_t;

  state_t          state;
  logic [IW-1:0]   init_idx;

  logic [COUNTER_WIDTH-1:0] pht     [PHT_ENTRIES];
  logic                     btb_vld [2][BTB_SETS];
  logic [TAG_W-1:0]         btb_tag [2][BTB_SETS];
  logic [DATA_WIDTH-1:0]    btb_tgt [2][BTB_SETS];
  logic                     btb_lru [BTB_SETS];

  logic [PHT_IDX-1:0] lk_pht_idx, up_pht_idx;
  logic [BTB_IDX-1:0] lk_set, up_set;
  logic [TAG_W-1:0]   lk_tag, up_tag;
  logic               lk_m0, lk_m1, up_m0, up_m1;
  logic               up_way;
  logic               unused_pc_lsbs;

  // Saturating counter step towards taken.
  function automatic logic [COUNTER_WIDTH-1:0] sat_inc(input logic [COUNTER_WIDTH-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

  // Saturating counter step towards not-taken.
  function automatic logic [COUNTER_WIDTH-1:0] sat_dec(input logic [COUNTER_WIDTH-1:0] c);
    return (c == '0) ? c : c - 1'b1;
  endfunction

  // Word-aligned PCs: the two low bits never take part in indexing.
  assign unused_pc_lsbs = ^{pc[1:0], resolved_pc[1:0]};

  assign lk_pht_idx = pc[PHT_IDX+1:2] ^ PHT_IDX'(ghr);
  assign lk_set     = pc[BTB_IDX+1:2];
  assign lk_tag     = pc[DATA_WIDTH-1:BTB_IDX+2];

  assign up_pht_idx = resolved_pc[PHT_IDX+1:2] ^ PHT_IDX'(resolved_ghr);
  assign up_set     = resolved_pc[BTB_IDX+1:2];
  assign up_tag     = resolved_pc[DATA_WIDTH-1:BTB_IDX+2];

  // Lookup: tag compare in both ways, outputs held at 0 until the sweep ends.
  always_comb begin
    lk_m0 = btb_vld[0][lk_set] && (btb_tag[0][lk_set] == lk_tag);
    lk_m1 = btb_vld[1][lk_set] && (btb_tag[1][lk_set] == lk_tag);
    hit   = ready && (lk_m0 || lk_m1);
    pred  = ready && pht[lk_pht_idx][COUNTER_WIDTH-1];
    branch_target = '0;
    if (ready && lk_m0)      branch_target = btb_tgt[0][lk_set];
    else if (ready && lk_m1) branch_target = btb_tgt[1][lk_set];
  end

  // Victim way selection: refresh a matching way, else first invalid way, else LRU.
  always_comb begin
    up_m0  = btb_vld[0][up_set] && (btb_tag[0][up_set] == up_tag);
    up_m1  = btb_vld[1][up_set] && (btb_tag[1][up_set] == up_tag);
    up_way = btb_lru[up_set];
    if (up_m0)                   up_way = 1'b0;
    else if (up_m1)              up_way = 1'b1;
    else if (!btb_vld[0][up_set]) up_way = 1'b0;
    else if (!btb_vld[1][up_set]) up_way = 1'b1;
  end

  // Control FSM: sweep every table index once, then stay READY until reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= S_INIT;
      init_idx <= '0;
      ready    <= 1'b0;
    end else begin
      case (state)
        S_INIT: begin
          init_idx <= init_idx + 1'b1;
          if (init_idx == IW'(INIT_N - 1)) begin
            state <= S_READY;
            ready <= 1'b1;
          end
        end
        default: state <= S_READY;
      endcase
    end
  end

  // Global history: shifted only by resolved branches, never speculatively.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ghr <= '0;
    end else if (state == S_READY && update_predictor) begin
      ghr <= GHR_WIDTH'({ghr, actually_taken});
    end
  end

  // PHT storage: weakly-not-taken fill during the sweep, training afterwards.
  always_ff @(posedge clk) begin
    if (state == S_INIT) begin
      if (32'(init_idx) < PHT_ENTRIES)
        pht[PHT_IDX'(init_idx)] <= CNT_INIT;
    end else if (update_predictor) begin
      pht[up_pht_idx] <= actually_taken ? sat_inc(pht[up_pht_idx])
                                        : sat_dec(pht[up_pht_idx]);
    end
  end

  // BTB storage: invalidate during the sweep, install/refresh afterwards.
  always_ff @(posedge clk) begin
    if (state == S_INIT) begin
      if (32'(init_idx) < BTB_SETS) begin
        btb_vld[0][BTB_IDX'(init_idx)] <= 1'b0;
        btb_vld[1][BTB_IDX'(init_idx)] <= 1'b0;
        btb_lru[BTB_IDX'(init_idx)]    <= 1'b0;
      end
    end else if (update_btb) begin
      btb_vld[up_way][up_set] <= 1'b1;
      btb_tag[up_way][up_set] <= up_tag;
      btb_tgt[up_way][up_set] <= resolved_pc_target;
      btb_lru[up_set]         <= ~up_way;
    end
  end

`ifdef BP_STATS_EN
  // Resolve-stage statistics, counted only once the tables are live.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat_updates     <= '0;
      stat_mispredicts <= '0;
    end else if (state == S_READY && update_predictor) begin
      stat_updates <= stat_updates + 32'd1;
      if (resolved_pred != actually_taken)
        stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed testbench for branch_predict_unit (default parameters, stats disabled).
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        rstn;
  logic        ready;
  logic [31:0] pc;
  logic        hit;
  logic        pred;
  logic [31:0] branch_target;
  logic [7:0]  ghr;
  logic        update_predictor;
  logic        update_btb;
  logic        actually_taken;
  logic [31:0] resolved_pc;
  logic [31:0] resolved_pc_target;
  logic [7:0]  resolved_ghr;

  int checks = 0;
  int errors = 0;
  logic [7:0] ghr_m;
  int cnt;

  always #5 clk = ~clk;

  branch_predict_unit dut (
    .clk                (clk),
    .rstn               (rstn),
    .ready              (ready),
    .pc                 (pc),
    .hit                (hit),
    .pred               (pred),
    .branch_target      (branch_target),
    .ghr                (ghr),
    .update_predictor   (update_predictor),
    .update_btb         (update_btb),
    .actually_taken     (actually_taken),
    .resolved_pc        (resolved_pc),
    .resolved_pc_target (resolved_pc_target),
    .resolved_ghr       (resolved_ghr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pht_upd(input logic [31:0] rpc, input logic [7:0] rg, input logic t);
    resolved_pc      = rpc;
    resolved_ghr     = rg;
    actually_taken   = t;
    update_predictor = 1'b1;
    step();
    update_predictor = 1'b0;
    ghr_m = {ghr_m[6:0], t};
  endtask

  task automatic btb_upd(input logic [31:0] rpc, input logic [31:0] tgt);
    resolved_pc        = rpc;
    resolved_pc_target = tgt;
    update_btb         = 1'b1;
    step();
    update_btb = 1'b0;
  endtask

  task automatic look(input string tag, input logic [31:0] lpc,
                      input logic exp_hit, input logic [31:0] exp_tgt);
    pc = lpc;
    #1;
    chk({tag, "_hit"}, 32'(hit), 32'(exp_hit));
    chk({tag, "_tgt"}, branch_target, exp_tgt);
  endtask

  // Look up the PHT entry idx under the current modelled history.
  task automatic pred_at(input string tag, input logic [7:0] idx, input logic exp);
    pc = {22'h0, idx ^ ghr_m, 2'b00};
    #1;
    chk(tag, 32'(pred), 32'(exp));
  endtask

  task automatic wait_ready(input string tag);
    cnt = 0;
    while (!ready && cnt < 1000) begin
      step();
      cnt++;
    end
    chk(tag, 32'(cnt), 32'd256);
  endtask

  initial begin
    rstn = 1'b0;
    pc = '0;
    update_predictor = 1'b0;
    update_btb = 1'b0;
    actually_taken = 1'b0;
    resolved_pc = '0;
    resolved_pc_target = '0;
    resolved_ghr = '0;
    ghr_m = '0;

    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_ghr", 32'(ghr), 32'd0);
    look("init", 32'h1000, 1'b0, 32'h0);
    chk("init_pred", 32'(pred), 32'd0);

    // Sweep; an update pulse during INIT must be ignored.
    cnt = 0;
    actually_taken = 1'b1;
    resolved_pc = 32'h5000;
    resolved_pc_target = 32'h6000;
    while (!ready && cnt < 1000) begin
      update_predictor = (cnt == 10);
      update_btb       = (cnt == 10);
      step();
      cnt++;
    end
    update_predictor = 1'b0;
    update_btb = 1'b0;
    chk("init_len", 32'(cnt), 32'd256);
    chk("init_ghr", 32'(ghr), 32'd0);
    look("init_upd_ignored", 32'h5000, 1'b0, 32'h0);

    // Direction training at idx 0x40.
    pht_upd(32'h100, 8'h00, 1'b1);
    pht_upd(32'h100, 8'h00, 1'b1);
    chk("train_ghr", 32'(ghr), 32'h03);
    pc = 32'h10C;
    #1;
    chk("train_pred", 32'(pred), 32'd1);
    pc = 32'h100;
    #1;
    chk("untouched_pred", 32'(pred), 32'd0);

    // Upper saturation: 3 + taken stays 3, two not-taken reach 1.
    repeat (3) pht_upd(32'h100, 8'h00, 1'b1);
    pred_at("sat_hi", 8'h40, 1'b1);
    pht_upd(32'h100, 8'h00, 1'b0);
    pred_at("sat_hi_dec1", 8'h40, 1'b1);
    pht_upd(32'h100, 8'h00, 1'b0);
    pred_at("sat_hi_dec2", 8'h40, 1'b0);
    chk("ghr_track", 32'(ghr), 32'(ghr_m));

    // Lower saturation at idx 0x10.
    pht_upd(32'h40, 8'h00, 1'b0);
    pht_upd(32'h40, 8'h00, 1'b0);
    pht_upd(32'h40, 8'h00, 1'b1);
    pred_at("sat_lo_inc1", 8'h10, 1'b0);
    pht_upd(32'h40, 8'h00, 1'b1);
    pred_at("sat_lo_inc2", 8'h10, 1'b1);

    // BTB install and tag discrimination (set 0).
    btb_upd(32'h1000, 32'h2000);
    look("btb_inst", 32'h1000, 1'b1, 32'h2000);
    look("btb_other_tag", 32'h1100, 1'b0, 32'h0);
    look("btb_other_set", 32'h1004, 1'b0, 32'h0);

    // LRU replacement.
    btb_upd(32'h1100, 32'h2100);
    btb_upd(32'h1200, 32'h2200);
    look("lru_evict", 32'h1000, 1'b0, 32'h0);
    look("lru_keep1", 32'h1100, 1'b1, 32'h2100);
    look("lru_keep2", 32'h1200, 1'b1, 32'h2200);

    // Refresh moves LRU away from the refreshed way.
    btb_upd(32'h1100, 32'h2110);
    look("refresh", 32'h1100, 1'b1, 32'h2110);
    btb_upd(32'h1300, 32'h2300);
    look("refresh_evict", 32'h1200, 1'b0, 32'h0);
    look("refresh_keep", 32'h1100, 1'b1, 32'h2110);
    look("refresh_new", 32'h1300, 1'b1, 32'h2300);

    // Same-cycle update and lookup sees old contents.
    pc = 32'h3000;
    resolved_pc = 32'h3000;
    resolved_pc_target = 32'h4000;
    update_btb = 1'b1;
    #1;
    chk("same_cycle_hit", 32'(hit), 32'd0);
    step();
    update_btb = 1'b0;
    #1;
    chk("next_cycle_hit", 32'(hit), 32'd1);
    chk("next_cycle_tgt", branch_target, 32'h4000);

    // Asynchronous reset, then reset again mid-sweep.
    rstn = 1'b0;
    #1;
    chk("arst_ready", 32'(ready), 32'd0);
    chk("arst_ghr", 32'(ghr), 32'd0);
    chk("arst_hit", 32'(hit), 32'd0);
    step();
    rstn = 1'b1;
    repeat (100) step();
    chk("mid_ready", 32'(ready), 32'd0);
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    ghr_m = '0;
    wait_ready("reinit_len");
    chk("reinit_ghr", 32'(ghr), 32'd0);
    look("reinit_btb", 32'h3000, 1'b0, 32'h0);
    pred_at("reinit_pht", 8'h10, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
